// File: rtl/hamming_pkg.sv
// hamming_pkg: shared states, bit positions, default bases and syndrome helper for the SECDED decoder
package hamming_pkg;
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} dec_state_t;
  localparam int P16_BIT = 0;
  localparam int P1_BIT = 1;
  localparam int P2_BIT = 2;
  localparam int P4_BIT = 4;
  localparam int P8_BIT = 8;
  localparam int DEF_NUM_WORDS = 15;
  localparam int DEF_SRC_BASE = 64;
  localparam int DEF_DST_BASE = 94;
  function automatic logic [3:0] hamming_syndrome(input logic [15:0] cw);
    logic [3:0] s;
    s = '0;
    for (int k = 1; k < 16; k++) s = cw[k] ? s ^ 4'(k) : s;
    return s;
  endfunction
endpackage

// File: rtl/secded_decode16.sv
// secded_decode16: combinational Hamming(16,11) SECDED correction and data extraction
module secded_decode16
  import hamming_pkg::*;
(
  input  logic [15:0] cw,
  output logic [11:1] data,
  output logic        single,
  output logic        double
);
  logic [3:0] s;
  logic p;
  logic [15:0] fixed;
  always_comb begin
    s = hamming_syndrome(cw);
    p = ^cw;
    single = p;
    double = (s != 4'd0) && !p;
    // s=0 with odd parity flips only p16, leaving data untouched
    fixed = p ? cw ^ (16'd1 << s) : cw;
    data = {fixed[15:9], fixed[7:5], fixed[3]};
  end
endmodule

// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder: walks NUM_WORDS codewords in memory, corrects/flags them and writes
// back 11-bit messages, pulsing ack when the block is done
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int SRC_BASE = DEF_SRC_BASE,
  parameter int DST_BASE = DEF_DST_BASE,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req,
  output logic          ack,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic [3:0]    n_single,
  output logic [3:0]    n_double
);
  dec_state_t state;
  logic [3:0] idx;
  logic [15:0] cw;
  logic [11:1] data;
  logic single, double;
  logic [AW-1:0] off;
  logic rd, hi;
  secded_decode16 u_dec (.cw(cw), .data(data), .single(single), .double(double));
  always_comb begin
    off = AW'({idx, 1'b0});
    rd = (state == RD_LO) || (state == RD_HI);
    hi = (state == RD_HI) || (state == WR_HI);
    mem_wr_en = (state == WR_LO) || (state == WR_HI);
    mem_addr = rd ? AW'(SRC_BASE) + off + AW'(hi) :
               mem_wr_en ? AW'(DST_BASE) + off + AW'(hi) : '0;
    mem_wr_data = (state == WR_LO) ? data[8:1] :
                  (state == WR_HI) ? {double, 4'b0, data[11:9]} : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      cw <= '0;
      ack <= 1'b0;
      n_single <= '0;
      n_double <= '0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: if (req) begin
          state <= RD_LO;
          idx <= '0;
          n_single <= '0;
          n_double <= '0;
        end
        RD_LO: begin
          cw[7:0] <= mem_rd_data;
          state <= RD_HI;
        end
        RD_HI: begin
          cw[15:8] <= mem_rd_data;
          state <= WR_LO;
        end
        WR_LO: state <= WR_HI;
        WR_HI: begin
          n_single <= (single && n_single != 4'hF) ? n_single + 4'd1 : n_single;
          n_double <= (double && n_double != 4'hF) ? n_double + 4'd1 : n_double;
          state <= (idx == 4'(NUM_WORDS - 1)) ? DONE : RD_LO;
          ack <= (idx == 4'(NUM_WORDS - 1));
          idx <= (idx == 4'(NUM_WORDS - 1)) ? idx : idx + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hamming_secded_decoder.sv
// tb_hamming_secded_decoder: directed runs with a write scoreboard against a reference SECDED model
module tb_hamming_secded_decoder;
  localparam int SRC = 64;
  localparam int DST = 94;
  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req = 1'b0;
  logic ack, mem_wr_en;
  logic [7:0] mem_addr, mem_rd_data, mem_wr_data;
  logic [3:0] n_single, n_double;
  logic [7:0] mem [256];
  logic ld_en = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [15:0] src [15];
  wr_t q[$];
  int checks = 0;
  int failures = 0;
  int es, ed, ack_k, ack_n;

  hamming_secded_decoder dut (
    .clk(clk), .reset_n(reset_n), .req(req), .ack(ack),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .n_single(n_single), .n_double(n_double)
  );

  always #5 clk = ~clk;
  assign mem_rd_data = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    else if (ld_en) mem[ld_addr] <= ld_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_t e;
      check("wr_pending", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wr_data, e.data);
      end
    end
  end

  function automatic logic [3:0] syn(input logic [15:0] w);
    logic [3:0] s = '0;
    for (int k = 1; k < 16; k++) if (w[k]) s ^= 4'(k);
    return s;
  endfunction

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c = '0;
    logic [3:0] s;
    c[3] = d[0];
    c[7:5] = d[3:1];
    c[15:9] = d[10:4];
    s = syn(c);
    c[1] = s[0];
    c[2] = s[1];
    c[4] = s[2];
    c[8] = s[3];
    c[0] = ^c;
    return c;
  endfunction

  function automatic void model(input logic [15:0] w, output logic [7:0] lo, output logic [7:0] hi,
                                output logic sg, output logic db);
    logic [3:0] s = syn(w);
    logic p = ^w;
    logic [15:0] c = w;
    logic [10:0] d;
    if (p && s != 0) c[s] = ~c[s];
    d = {c[15:9], c[7:5], c[3]};
    sg = p;
    db = (s != 0) && !p;
    lo = d[7:0];
    hi = {db, 4'b0, d[10:8]};
  endfunction

  task automatic load_byte(input int a, input logic [7:0] d);
    ld_en = 1'b1;
    ld_addr = 8'(a);
    ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 15; i++) begin
      load_byte(SRC + 2 * i, src[i][7:0]);
      load_byte(SRC + 2 * i + 1, src[i][15:8]);
    end
  endtask

  task automatic push_expected(input int upto);
    logic [7:0] lo, hi;
    logic sg, db;
    es = 0;
    ed = 0;
    for (int i = 0; i < upto; i++) begin
      model(src[i], lo, hi, sg, db);
      q.push_back('{8'(DST + 2 * i), lo});
      q.push_back('{8'(DST + 2 * i + 1), hi});
      es += int'(sg);
      ed += int'(db);
    end
  endtask

  task automatic run_watch(input int repulse_k);
    @(posedge clk);
    #1 req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    ack_k = -1;
    ack_n = 0;
    for (int k = 1; k <= 80; k++) begin
      req = (k == repulse_k);
      @(posedge clk);
      #1;
      if (ack) begin
        ack_n++;
        if (ack_k < 0) ack_k = k;
      end
    end
    req = 1'b0;
  endtask

  task automatic full_run(input string tag, input int repulse_k);
    load_all();
    push_expected(15);
    run_watch(repulse_k);
    check({tag, "_ack_cycle"}, ack_k, 60);
    check({tag, "_ack_count"}, ack_n, 1);
    check({tag, "_n_single"}, n_single, es);
    check({tag, "_n_double"}, n_double, ed);
    check({tag, "_queue_drained"}, q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wr_data", mem_wr_data, 0);
    check("rst_n_single", n_single, 0);
    check("rst_n_double", n_double, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) src[i] = 16'h0000;
    full_run("zeros", 0);
    src[0] = 16'hFFDF;
    src[3] = 16'hFDDF;
    src[7] = 16'hFFFE;
    full_run("flips", 20);
    check("w0_lo", mem[DST], 8'hFF);
    check("w0_hi", mem[DST + 1], 8'h07);
    check("w3_hi", mem[DST + 7], 8'h87);
    check("w3_lo", mem[DST + 6], 8'hED);
    check("w7_lo", mem[DST + 14], 8'hFF);
    check("w7_hi", mem[DST + 15], 8'h07);
    check("w1_hi", mem[DST + 3], 8'h00);
    for (int i = 0; i < 15; i++) begin
      logic [15:0] w = encode(11'($urandom));
      int nf = $urandom_range(2);
      int b1 = $urandom_range(15);
      int b2 = (b1 + $urandom_range(1, 15)) % 16;
      if (nf >= 1) w[b1] = ~w[b1];
      if (nf == 2) w[b2] = ~w[b2];
      src[i] = w;
    end
    full_run("random", 0);
    for (int a = DST; a < DST + 30; a++) load_byte(a, 8'hA5);
    load_all();
    push_expected(7);
    @(posedge clk);
    #1 req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (29) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_ack", ack, 0);
    check("mid_rst_wr_en", mem_wr_en, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_n_single", n_single, 0);
    check("mid_rst_n_double", n_double, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check("mid_rst_queue_drained", q.size(), 0);
    check("mid_rst_w6_hi_written", mem[DST + 13] != 8'hA5, 1);
    for (int a = DST + 14; a < DST + 30; a++) check("mid_rst_untouched", mem[a], 8'hA5);
    full_run("after_rst", 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
